// File: rtl/any1_bus_sram.sv
// ---------------------------------------------------------------------------
// any1_bus_sram
//
// 128-bit Wishbone-classic slave scratchpad RAM for the any1oo CPU bus port.
// It decodes its own address window, performs byte-lane-masked writes and
// registered reads, and inserts a programmable number of wait states between
// capturing a request and acknowledging it.
//
// Parameters:
//   AW          log2 of the depth in 128-bit words (depth = 2**AW)
//   BASE        window base address, compared on adr_i[31:AW+4]
//   WAIT_STATES idle cycles between request capture and ack (0..15)
//
// Ports:
//   clk_i   in   1    clock, all state changes on its rising edge
//   rst_ni  in   1    asynchronous active-low reset
//   cyc_i   in   1    bus cycle valid
//   stb_i   in   1    strobe
//   we_i    in   1    1 = write, 0 = read
//   sel_i   in   16   byte-lane enables, bit n covers dat[8n+7:8n]
//   adr_i   in   32   byte address, bits [3:0] ignored
//   dat_i   in   128  write data
//   ack_o   out  1    transfer acknowledge
//   dat_o   out  128  read data, held until the next read completes
// ---------------------------------------------------------------------------
module any1_bus_sram #(
    parameter int unsigned AW          = 10,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cyc_i,
    input  logic         stb_i,
    input  logic         we_i,
    input  logic [15:0]  sel_i,
    input  logic [31:0]  adr_i,
    input  logic [127:0] dat_i,
    output logic         ack_o,
    output logic [127:0] dat_o
);

    localparam int unsigned DEPTH     = 2 ** AW;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic            we_q;
    logic [15:0]     sel_q;
    logic [127:0]    wdat_q;
    logic [127:0]    rdat_q;

    logic [127:0]    mem_q [DEPTH];

    logic            busReq;
    logic            hit;
    logic            capture;
    logic            doAccess;
    logic            accFromBus;
    logic [AW-1:0]   accIdx;
    logic            accWe;
    logic [15:0]     accSel;
    logic [127:0]    accDat;

    // Byte offset bits never take part in decode; the name keeps lint quiet.
    logic            unusedAdrBits;
    assign unusedAdrBits = ^adr_i[3:0];

    // Request qualification and window decode on the upper address bits.
    assign busReq = cyc_i & stb_i;
    assign hit    = busReq & (adr_i[31:AW+4] == BASE[31:AW+4]);

    // Ack is gated by the live strobe so it drops as soon as the master
    // releases the bus, and immediately when reset forces IDLE.
    assign ack_o = (state_q == ACK) & busReq;
    assign dat_o = rdat_q;

    // Next-state logic. The count is loaded with WAIT_STATES on capture and
    // the access fires on the WAIT edge that sees it at 1, so ack follows the
    // capture edge by exactly WAIT_STATES edges. Dropping the strobe while
    // waiting abandons the transfer without touching memory or dat_o.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        doAccess = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        doAccess = 1'b1;
                        state_d  = ACK;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!busReq) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        doAccess = 1'b1;
                        state_d  = ACK;
                    end
                end
            end
            ACK: begin
                if (!busReq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the capture edge itself,
    // so the bus fields are used directly; otherwise the latched copies are
    // used and later changes on the bus are ignored.
    always_comb begin
        accFromBus = (state_q == IDLE);
        accIdx     = accFromBus ? adr_i[AW+3:4] : idx_q;
        accWe      = accFromBus ? we_i          : we_q;
        accSel     = accFromBus ? sel_i         : sel_q;
        accDat     = accFromBus ? dat_i         : wdat_q;
    end

    // Control state, captured request and read data register. Everything
    // except the memory array itself is cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q  <= adr_i[AW+3:4];
                we_q   <= we_i;
                sel_q  <= sel_i;
                wdat_q <= dat_i;
            end
            if (doAccess && !accWe) begin
                rdat_q <= mem_q[accIdx];
            end
        end
    end

    // Memory array, byte-lane masked write. Contents survive reset; the
    // rst_ni term only stops a write slipping through while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && doAccess && accWe) begin
            for (int n = 0; n < 16; n++) begin
                if (accSel[n]) begin
                    mem_q[accIdx][8*n +: 8] <= accDat[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_any1_bus_sram.sv
// ---------------------------------------------------------------------------
// tb_any1_bus_sram
//
// Self-checking bench for any1_bus_sram. Instance A uses the default single
// wait state, instance B uses three. Both share the bus fields and reset but
// have their own strobe so only one of them sees a request at a time.
// ---------------------------------------------------------------------------
module tb_any1_bus_sram;

    typedef struct {
        bit           we;
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] dat;
        logic [127:0] exp;
        string        name;
    } vec_t;

    localparam logic [127:0] V1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] V2 = 128'hDEADBEEF_CAFEF00D_55AA33CC_0F1E2D3C;
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    logic         clk;
    logic         rstN;
    logic         cyc;
    logic         stbA;
    logic         stbB;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] datIn;
    logic         ackA;
    logic         ackB;
    logic [127:0] datA;
    logic [127:0] datB;

    int           testsRun;
    int           failCount;
    logic [127:0] lastA;
    logic [127:0] lastB;
    logic [127:0] sbQ[$];
    vec_t         vecs[12];

    any1_bus_sram #(.AW(10), .BASE(32'h0), .WAIT_STATES(1)) u_dutA (
        .clk_i  (clk),
        .rst_ni (rstN),
        .cyc_i  (cyc),
        .stb_i  (stbA),
        .we_i   (we),
        .sel_i  (sel),
        .adr_i  (adr),
        .dat_i  (datIn),
        .ack_o  (ackA),
        .dat_o  (datA)
    );

    any1_bus_sram #(.AW(10), .BASE(32'h0), .WAIT_STATES(3)) u_dutB (
        .clk_i  (clk),
        .rst_ni (rstN),
        .cyc_i  (cyc),
        .stb_i  (stbB),
        .we_i   (we),
        .sel_i  (sel),
        .adr_i  (adr),
        .dat_i  (datIn),
        .ack_o  (ackB),
        .dat_o  (datB)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(input bit w, input logic [31:0] a,
                                   input logic [15:0] s, input logic [127:0] d,
                                   input logic [127:0] e, input string n);
        vec_t v;
        v.we = w; v.adr = a; v.sel = s; v.dat = d; v.exp = e; v.name = n;
        return v;
    endfunction

    // One complete transfer: drive, wait (bounded) for ack, check latency,
    // check read data from the scoreboard or that dat_o held, release bus.
    task automatic applyStimulus(input bit useB, input vec_t v, input int expLat);
        int           edges;
        bit           got;
        logic [127:0] expDat;
        @(negedge clk);
        cyc   = 1'b1;
        we    = v.we;
        adr   = v.adr;
        sel   = v.sel;
        datIn = v.dat;
        if (useB) stbB = 1'b1; else stbA = 1'b1;
        if (!v.we) sbQ.push_back(v.exp);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            got = useB ? ackB : ackA;
        end
        checkOutput({v.name, " ack latency"}, 128'(edges), 128'(expLat));
        if (!v.we) begin
            if (got && sbQ.size() > 0) begin
                expDat = sbQ.pop_front();
                checkOutput({v.name, " rdata"}, useB ? datB : datA, expDat);
                if (useB) lastB = expDat; else lastA = expDat;
            end else begin
                sbQ.delete();
            end
        end else begin
            checkOutput({v.name, " dat_o hold"}, useB ? datB : datA,
                        useB ? lastB : lastA);
        end
        @(negedge clk);
        cyc  = 1'b0;
        stbA = 1'b0;
        stbB = 1'b0;
    endtask

    initial begin
        int  edges;
        bit  sawAck;
        bit  got;

        testsRun  = 0;
        failCount = 0;
        lastA     = '0;
        lastB     = '0;
        rstN  = 1'b1;
        cyc   = 1'b0;
        stbA  = 1'b0;
        stbB  = 1'b0;
        we    = 1'b0;
        sel   = '0;
        adr   = '0;
        datIn = '0;

        vecs[0]  = mkVec(1, 32'h10,   16'hFFFF, V1,            '0, "wr_full");
        vecs[1]  = mkVec(0, 32'h10,   16'hFFFF, '0,            V1, "rd_full");
        vecs[2]  = mkVec(1, 32'h30,   16'hFFFF, '0,            '0, "prefill3");
        vecs[3]  = mkVec(1, 32'h30,   16'h8001, {16{8'hAA}},   '0, "wr_lanes");
        vecs[4]  = mkVec(0, 32'h30,   16'h0000, '0,
                         128'hAA000000_00000000_00000000_000000AA, "rd_lanes");
        vecs[5]  = mkVec(1, 32'h20,   16'hFFFF, {16{8'h11}},   '0, "fill2");
        vecs[6]  = mkVec(1, 32'h20,   16'h0F00, {16{8'hFF}},   '0, "wr_mid");
        vecs[7]  = mkVec(0, 32'h20,   16'hFFFF, '0,
                         128'h11111111_FFFFFFFF_11111111_11111111, "rd_mid");
        vecs[8]  = mkVec(1, 32'h10,   16'h0000, '0,            '0, "wr_sel0");
        vecs[9]  = mkVec(0, 32'h1F,   16'hFFFF, '0,            V1, "rd_alias");
        vecs[10] = mkVec(1, 32'h3FF0, 16'hFFFF, V2,            '0, "wr_top");
        vecs[11] = mkVec(0, 32'h3FF0, 16'hFFFF, '0,            V2, "rd_top");

        // Reset values
        #2 rstN = 1'b0;
        #1;
        checkOutput("reset ackA", 128'(ackA), 128'(0));
        checkOutput("reset ackB", 128'(ackB), 128'(0));
        checkOutput("reset datA", datA, '0);
        checkOutput("reset datB", datB, '0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Table-driven transfers on the single-wait-state instance
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, vecs[i], LAT_A);
        end

        // Three wait states: held read, ack exactly after the 4th edge
        applyStimulus(1'b1, mkVec(1, 32'h50, 16'hFFFF, V1, '0, "B_wr50"), LAT_B);
        @(negedge clk);
        cyc = 1'b1; we = 1'b0; adr = 32'h50; sel = 16'hFFFF; stbB = 1'b1;
        sbQ.push_back(V1);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("B_hold_rd ack edge %0d", e), 128'(ackB),
                        128'(e >= 4));
            if (e == 4 && sbQ.size() > 0) begin
                lastB = sbQ.pop_front();
                checkOutput("B_hold_rd rdata", datB, lastB);
            end
        end
        sbQ.delete();
        @(negedge clk);
        cyc = 1'b0; stbB = 1'b0;

        // Held write whose bus data changes after capture: only the captured
        // value may land, exactly once
        @(negedge clk);
        cyc = 1'b1; we = 1'b1; adr = 32'h60; sel = 16'hFFFF; datIn = V2; stbB = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) datIn = ~V2;
            checkOutput($sformatf("B_hold_wr ack edge %0d", e), 128'(ackB),
                        128'(e >= 4));
        end
        @(negedge clk);
        cyc = 1'b0; stbB = 1'b0;
        applyStimulus(1'b1, mkVec(0, 32'h60, 16'hFFFF, '0, V2, "B_rd60"), LAT_B);

        // Abort: strobe dropped while waiting, no ack and no write
        applyStimulus(1'b0, mkVec(1, 32'h40, 16'hFFFF, V1, '0, "wr40"), LAT_A);
        @(negedge clk);
        cyc = 1'b1; we = 1'b1; adr = 32'h40; sel = 16'hFFFF; datIn = V2; stbA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 1'b0; stbA = 1'b0;
        sawAck = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ackA) sawAck = 1'b1;
        end
        checkOutput("abort no ack", 128'(sawAck), 128'(0));
        checkOutput("abort dat_o hold", datA, lastA);
        applyStimulus(1'b0, mkVec(0, 32'h40, 16'hFFFF, '0, V1, "abort rd40"), LAT_A);

        // Out of window: never acked, dat_o untouched
        @(negedge clk);
        cyc = 1'b1; we = 1'b0; adr = 32'hFF00_0000; sel = 16'hFFFF; stbA = 1'b1;
        sawAck = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ackA) sawAck = 1'b1;
        end
        checkOutput("oow no ack", 128'(sawAck), 128'(0));
        checkOutput("oow dat_o hold", datA, lastA);
        @(negedge clk);
        cyc = 1'b0; stbA = 1'b0;

        // Reset while in ACK: ack falls without waiting for a clock
        @(negedge clk);
        cyc = 1'b1; we = 1'b0; adr = 32'h10; stbA = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
            got = ackA;
        end
        checkOutput("rst_ack ack seen", 128'(got), 128'(1));
        #2 rstN = 1'b0;
        #1;
        checkOutput("rst_ack ack async", 128'(ackA), 128'(0));
        checkOutput("rst_ack dat cleared", datA, '0);
        @(negedge clk);
        cyc = 1'b0; stbA = 1'b0;
        @(negedge clk);
        rstN  = 1'b1;
        lastA = '0;
        lastB = '0;

        // Reset while waiting on a write: the write is dropped
        applyStimulus(1'b1, mkVec(1, 32'h70, 16'hFFFF, V1, '0, "B_wr70"), LAT_B);
        @(negedge clk);
        cyc = 1'b1; we = 1'b1; adr = 32'h70; sel = 16'hFFFF; datIn = V2; stbB = 1'b1;
        @(posedge clk);
        #3 rstN = 1'b0;
        #1;
        checkOutput("rst_wait ackB", 128'(ackB), 128'(0));
        @(negedge clk);
        cyc = 1'b0; stbB = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b1, mkVec(0, 32'h70, 16'hFFFF, '0, V1, "B_rst_rd70"), LAT_B);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
